// File: rtl/segway_a2d_pkg.sv
// Shared types and constants for the round-robin A2D scheduler:
// FSM states, channel map and SPI command word layout.
package segway_a2d_pkg;

    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned RES_W  = 12;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CH_W-1:0] CH_LFT   = 3'd0;
    localparam logic [CH_W-1:0] CH_RGHT  = 3'd4;
    localparam logic [CH_W-1:0] CH_STEER = 3'd5;
    localparam logic [CH_W-1:0] CH_BATT  = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD_WAIT = 2'd1,
        GAP      = 2'd2,
        RD_WAIT  = 2'd3
    } a2d_state_t;

    typedef logic [PTR_W-1:0] rr_ptr_t;

    // A2D command word: {2'b00, channel, 11'h000}
    typedef struct packed {
        logic [1:0]      rsvd;
        logic [CH_W-1:0] ch;
        logic [10:0]     pad;
    } a2d_cmd_t;

    function automatic logic [CH_W-1:0] ptr_to_ch(input rr_ptr_t ptr);
        logic [CH_W-1:0] ch;
        case (ptr)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return ch;
    endfunction

    function automatic a2d_cmd_t make_cmd(input logic [CH_W-1:0] ch);
        a2d_cmd_t cmd;
        cmd.rsvd = 2'b00;
        cmd.ch   = ch;
        cmd.pad  = 11'h000;
        return cmd;
    endfunction

endpackage

// File: rtl/a2d_watchdog.sv
// Loadable counter with terminal-count detect; counts up (timeout)
// or down (dead-gap) depending on COUNT_DOWN.
module a2d_watchdog
    import segway_a2d_pkg::*;
#(
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt;

    // clr has priority so a restart always begins from load_val
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= COUNT_DOWN ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
        end
    end

    assign expired_c = (cnt == term);

endmodule

// File: rtl/a2d_rr_scheduler.sv
// Round-robin sequencer driving the shared SPI master: command transaction,
// dead gap, read transaction, result capture, with a done-timeout watchdog.
module a2d_rr_scheduler
    import segway_a2d_pkg::*;
#(
    parameter int unsigned DEAD_CYC    = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        nxt,
    input  logic        clr_err,
    output logic        wrt,
    output logic [15:0] wrt_data,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt,
    output logic        timeout_err
);

    a2d_state_t        state_q, state_d;
    rr_ptr_t           ptr_q, ptr_d;
    logic              wrt_d, busy_d, cnv_d, err_d;
    logic [WORD_W-1:0] wrt_data_d;
    logic              ld_en_c, gap_load_c, to_clr_c;
    logic              gap_exp_c, to_exp_c;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    a2d_watchdog #(.COUNT_DOWN(1'b1)) u_gap (
        .clk       (clk),
        .rst_n     (RST_n),
        .clr       (gap_load_c),
        .en        (state_q == GAP),
        .load_val  (CNT_W'(DEAD_CYC)),
        .term      (CNT_W'(1)),
        .expired_c (gap_exp_c)
    );

    // Expires with TIMEOUT_CYC-1 counted so the abort lands TIMEOUT_CYC cycles after wrt
    a2d_watchdog #(.COUNT_DOWN(1'b0)) u_timeout (
        .clk       (clk),
        .rst_n     (RST_n),
        .clr       (to_clr_c),
        .en        ((state_q == CMD_WAIT) || (state_q == RD_WAIT)),
        .load_val  (CNT_W'(0)),
        .term      (CNT_W'(TIMEOUT_CYC - 1)),
        .expired_c (to_exp_c)
    );

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wrt         <= 1'b0;
            wrt_data    <= '0;
            busy        <= 1'b0;
            cnv_cmplt   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wrt         <= wrt_d;
            wrt_data    <= wrt_data_d;
            busy        <= busy_d;
            cnv_cmplt   <= cnv_d;
            timeout_err <= err_d;
        end
    end

    // done is checked before the watchdog so a late done still wins
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wrt_d      = 1'b0;
        wrt_data_d = wrt_data;
        busy_d     = busy;
        cnv_d      = 1'b0;
        err_d      = timeout_err & ~clr_err;
        ld_en_c    = 1'b0;
        gap_load_c = 1'b0;
        to_clr_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    state_d    = CMD_WAIT;
                    wrt_d      = 1'b1;
                    wrt_data_d = make_cmd(ptr_to_ch(ptr_q));
                    busy_d     = 1'b1;
                    to_clr_c   = 1'b1;
                end
            end
            CMD_WAIT: begin
                if (done) begin
                    state_d    = GAP;
                    gap_load_c = 1'b1;
                end else if (to_exp_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            GAP: begin
                if (gap_exp_c) begin
                    state_d    = RD_WAIT;
                    wrt_d      = 1'b1;
                    wrt_data_d = '0;
                    to_clr_c   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnv_d   = 1'b1;
                    ld_en_c = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                end else if (to_exp_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else if (ld_en_c) begin
            case (ptr_q)
                2'd0:    lft_ld    <= rd_data[RES_W-1:0];
                2'd1:    rght_ld   <= rd_data[RES_W-1:0];
                2'd2:    steer_pot <= rd_data[RES_W-1:0];
                default: batt      <= rd_data[RES_W-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_scheduler.sv
// Randomized self-checking bench for a2d_rr_scheduler with a behavioural
// channel/result model and a scripted SPI master responder.
module tb_a2d_rr_scheduler;

    localparam int DEAD = 2;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        RST_n, nxt, clr_err, done;
    logic [15:0] rd_data;
    logic        wrt, busy, cnv_cmplt, timeout_err;
    logic [15:0] wrt_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    int errors = 0;
    int checks = 0;
    int cnv_seen = 0;

    int          exp_ptr;
    logic [11:0] exp_reg [4];
    int          ch_tab  [4] = '{0, 4, 5, 6};

    a2d_rr_scheduler #(.DEAD_CYC(DEAD), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .RST_n(RST_n), .nxt(nxt), .clr_err(clr_err),
        .wrt(wrt), .wrt_data(wrt_data), .done(done), .rd_data(rd_data),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .busy(busy), .cnv_cmplt(cnv_cmplt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnv_cmplt === 1'b1) cnv_seen++;
    endtask

    function automatic logic [15:0] exp_cmd(input int p);
        int v;
        v = ch_tab[p] * 2048;
        return 16'(v);
    endfunction

    function automatic logic [47:0] exp_all();
        return {exp_reg[0], exp_reg[1], exp_reg[2], exp_reg[3]};
    endfunction

    task automatic model_reset();
        exp_ptr = 0;
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
    endtask

    task automatic model_convert(input logic [15:0] v);
        exp_reg[exp_ptr] = v & 16'h0FFF;
        exp_ptr = (exp_ptr + 1) % 4;
    endtask

    task automatic apply_reset();
        RST_n = 1'b0; nxt = 1'b0; done = 1'b0; clr_err = 1'b0; rd_data = 16'h0;
        tick(); tick();
        RST_n = 1'b1;
        tick();
        model_reset();
    endtask

    // Plays the SPI master: lat < 0 withholds done and waits for the abort
    task automatic run_conv(input logic [15:0] rd_val, input int lat_cmd, input int lat_rd,
                            input bit spam, output logic [15:0] cmd_w, output logic [15:0] rd_w,
                            output int gap, output int to_cyc, output int stray, output bit ok);
        int k;
        ok = 1'b0; gap = -1; to_cyc = -1; stray = 0; cmd_w = 16'hxxxx; rd_w = 16'hxxxx;
        nxt = 1'b1; tick(); nxt = 1'b0;
        k = 0;
        while (wrt !== 1'b1 && k < 20) begin tick(); k++; end
        if (wrt !== 1'b1) return;
        cmd_w = wrt_data;
        if (lat_cmd < 0) begin
            k = 0;
            while (timeout_err !== 1'b1 && k < 4 * TMO) begin tick(); k++; end
            to_cyc = k; ok = 1'b1;
            return;
        end
        for (int i = 0; i < lat_cmd; i++) begin
            if (spam && i < 3) nxt = 1'b1;
            tick();
            nxt = 1'b0;
        end
        done = 1'b1; tick(); done = 1'b0;
        gap = 0;
        while (wrt !== 1'b1 && gap < 300) begin
            if (spam && gap == 0) done = 1'b1;
            tick();
            done = 1'b0;
            gap++;
        end
        if (wrt !== 1'b1) return;
        rd_w = wrt_data;
        if (lat_rd < 0) begin
            k = 0;
            while (timeout_err !== 1'b1 && k < 4 * TMO) begin tick(); k++; end
            to_cyc = k; ok = 1'b1;
            return;
        end
        repeat (lat_rd) tick();
        done = 1'b1; rd_data = rd_val;
        if (spam) nxt = 1'b1;
        tick();
        done = 1'b0; nxt = 1'b0; rd_data = 16'(($urandom));
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wrt === 1'b1) stray++;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        int c0;
        apply_reset();
        checks++;
        if ({wrt, busy, cnv_cmplt, timeout_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {wrt, busy, cnv_cmplt, timeout_err});
        end
        checks++;
        if (wrt_data !== 16'h0000) begin
            errors++; $display("FAIL reset_wrt_data: got %h expected 0000", wrt_data);
        end
        checks++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {lft_ld, rght_ld, steer_pot, batt});
        end
        c0 = cnv_seen;
        done = 1'b1; rd_data = 16'h0FFF; tick(); done = 1'b0; tick(); tick();
        checks++;
        if ({wrt, busy, lft_ld} !== 14'h0 || cnv_seen != c0) begin
            errors++; $display("FAIL done_in_idle: got wrt=%b busy=%b lft=%h cnv=%0d expected all 0",
                               wrt, busy, lft_ld, cnv_seen - c0);
        end
    endtask

    task automatic test_single();
        logic [15:0] cw, rw; int gap, to, stray, c0; bit ok;
        c0 = cnv_seen;
        run_conv(16'h0ABC, 2, 3, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'h0ABC);
        checks++;
        if (!ok || cw !== 16'h0000 || rw !== 16'h0000) begin
            errors++; $display("FAIL single_words: got ok=%0d cmd=%h rd=%h expected 1/0000/0000", ok, cw, rw);
        end
        checks++;
        if (gap != DEAD) begin
            errors++; $display("FAIL single_gap: got %0d expected %0d", gap, DEAD);
        end
        checks++;
        if (lft_ld !== 12'hABC || cnv_seen - c0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_result: got lft=%h cnv=%0d busy=%b expected abc/1/0",
                               lft_ld, cnv_seen - c0, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] fixed [4] = '{16'h0123, 16'h0456, 16'h0789, 16'h0FFF};
        logic [15:0] v, cw, rw; int gap, to, stray, c0; bit ok; logic [15:0] ecmd;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            v = (i < 4) ? fixed[i] : 16'($urandom);
            ecmd = exp_cmd(exp_ptr);
            c0 = cnv_seen;
            run_conv(v, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0,
                     cw, rw, gap, to, stray, ok);
            model_convert(v);
            checks++;
            if (!ok || cw !== ecmd || rw !== 16'h0000) begin
                errors++; $display("FAIL rr_cmd[%0d]: got ok=%0d cmd=%h rd=%h expected %h/0000", i, ok, cw, rw, ecmd);
            end
            checks++;
            if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all() || cnv_seen - c0 != 1) begin
                errors++; $display("FAIL rr_regs[%0d]: got %h cnv=%0d expected %h cnv=1", i,
                                   {lft_ld, rght_ld, steer_pot, batt}, cnv_seen - c0, exp_all());
            end
        end
    endtask

    task automatic test_upper_bits();
        logic [15:0] cw, rw; int gap, to, stray, p; bit ok; logic [11:0] got;
        p = exp_ptr;
        run_conv(16'hF5A5, 1, 2, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'hF5A5);
        case (p)
            0: got = lft_ld;
            1: got = rght_ld;
            2: got = steer_pot;
            default: got = batt;
        endcase
        checks++;
        if (!ok || got !== 12'h5A5) begin
            errors++; $display("FAIL upper_bits: got %h expected 5a5", got);
        end
    endtask

    task automatic test_busy_drop();
        logic [15:0] cw, rw, ecmd; int gap, to, stray, c0; bit ok;
        c0 = cnv_seen;
        run_conv(16'h0321, 5, 1, 1'b1, cw, rw, gap, to, stray, ok);
        model_convert(16'h0321);
        checks++;
        if (!ok || cnv_seen - c0 != 1 || stray != 0 || gap != DEAD) begin
            errors++; $display("FAIL busy_drop: got ok=%0d cnv=%0d stray_wrt=%0d gap=%0d expected 1/1/0/%0d",
                               ok, cnv_seen - c0, stray, gap, DEAD);
        end
        ecmd = exp_cmd(exp_ptr);
        run_conv(16'h0654, 0, 0, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'h0654);
        checks++;
        if (!ok || cw !== ecmd || {lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
            errors++; $display("FAIL busy_next: got cmd=%h regs=%h expected %h/%h",
                               cw, {lft_ld, rght_ld, steer_pot, batt}, ecmd, exp_all());
        end
    endtask

    task automatic test_timeout();
        logic [15:0] cw, rw, ecmd; int gap, to, stray, c0, k; bit ok;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        ecmd = exp_cmd(exp_ptr);
        c0 = cnv_seen;
        run_conv(16'h0111, -1, 0, 1'b0, cw, rw, gap, to, stray, ok);
        checks++;
        if (to != TMO || busy !== 1'b0 || cnv_seen != c0 || {lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
            errors++; $display("FAIL timeout_cmd: got cyc=%0d busy=%b cnv=%0d expected %0d/0/0",
                               to, busy, cnv_seen - c0, TMO);
        end
        run_conv(16'h0222, 2, 2, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'h0222);
        checks++;
        if (!ok || cw !== ecmd || timeout_err !== 1'b1 || {lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
            errors++; $display("FAIL timeout_retry: got cmd=%h err=%b expected %h/1", cw, timeout_err, ecmd);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL clr_err: got %b expected 0", timeout_err);
        end
        ecmd = exp_cmd(exp_ptr);
        c0 = cnv_seen;
        run_conv(16'h0333, 1, -1, 1'b0, cw, rw, gap, to, stray, ok);
        checks++;
        if (to != TMO || busy !== 1'b0 || cnv_seen != c0 || {lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
            errors++; $display("FAIL timeout_rd: got cyc=%0d busy=%b cnv=%0d expected %0d/0/0",
                               to, busy, cnv_seen - c0, TMO);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        nxt = 1'b1; tick(); nxt = 1'b0;
        checks++;
        if (wrt !== 1'b1 || wrt_data !== ecmd) begin
            errors++; $display("FAIL timeout_same_ch: got wrt=%b data=%h expected 1/%h", wrt, wrt_data, ecmd);
        end
        for (k = 0; k < TMO; k++) begin
            if (k == TMO - 1) clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL clr_vs_timeout: got err=%b busy=%b expected 1/0", timeout_err, busy);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        c0 = cnv_seen;
        run_conv(16'h0444, TMO - 1, TMO - 1, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'h0444);
        checks++;
        if (!ok || cw !== ecmd || timeout_err !== 1'b0 || cnv_seen - c0 != 1 ||
            {lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
            errors++; $display("FAIL done_wins: got ok=%0d cmd=%h err=%b cnv=%0d expected 1/%h/0/1",
                               ok, cw, timeout_err, cnv_seen - c0, ecmd);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] cw, rw; int gap, to, stray, k; bit ok;
        nxt = 1'b1; tick(); nxt = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        k = 0;
        while (wrt !== 1'b1 && k < 50) begin tick(); k++; end
        checks++;
        if (wrt !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got wrt=%b busy=%b expected 1/1", wrt, busy);
        end
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if ({wrt, busy, cnv_cmplt, timeout_err} !== 4'b0000 || wrt_data !== 16'h0 ||
            {lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            errors++; $display("FAIL async_reset: got flags=%b data=%h regs=%h expected 0",
                               {wrt, busy, cnv_cmplt, timeout_err}, wrt_data, {lft_ld, rght_ld, steer_pot, batt});
        end
        tick();
        RST_n = 1'b1;
        tick();
        model_reset();
        run_conv(16'h0DEF, 1, 1, 1'b0, cw, rw, gap, to, stray, ok);
        model_convert(16'h0DEF);
        checks++;
        if (!ok || cw !== 16'h0000 || lft_ld !== 12'hDEF) begin
            errors++; $display("FAIL post_reset: got ok=%0d cmd=%h lft=%h expected 1/0000/def", ok, cw, lft_ld);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_upper_bits();
        test_busy_drop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
